// File: rtl/cla_pkg.sv
// Shared types and constants for the nibble-serial CLA adder slice.
package cla_pkg;

    localparam int NIBBLE_W        = 4;
    localparam int CLA_DEFAULT_LAT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/cla_nibble_sequencer.sv
// Feeds wide operands nibble-by-nibble (LSB first) through an external registered
// 4-bit CLA, chaining carries, and returns sum/cout/ovf over a valid/ready handshake.
module cla_nibble_sequencer
    import cla_pkg::*;
#(
    parameter int NIBBLES = 4,
    parameter int CLA_LAT = CLA_DEFAULT_LAT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    input  logic                        cin,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] sum,
    output logic                        cout,
    output logic                        ovf,
    output logic [NIBBLE_W-1:0]         cla_a,
    output logic [NIBBLE_W-1:0]         cla_b,
    output logic                        cla_c0,
    input  logic [NIBBLE_W-1:0]         cla_s,
    input  logic                        cla_cout
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int CNT_W = (CLA_LAT > 0) ? $clog2(CLA_LAT + 1) : 1;

    seq_state_t          r_state;
    seq_state_t          w_state_nxt;
    logic [W-1:0]        r_a;
    logic [W-1:0]        r_b;
    logic [W-1:0]        r_sum;
    logic                r_carry;
    logic                r_ovf;
    logic [IDX_W-1:0]    r_idx;
    logic [CNT_W-1:0]    r_cnt;
    logic [NIBBLE_W-1:0] r_cla_a;
    logic [NIBBLE_W-1:0] r_cla_b;

    logic                w_accept;
    logic                w_capture;
    logic                w_last;
    logic [IDX_W-1:0]    w_idx_nxt;

    assign w_accept  = (r_state == IDLE) & in_valid;
    assign w_capture = (r_state == RUN) & (r_cnt == CNT_W'(CLA_LAT));
    assign w_last    = (r_idx == IDX_W'(NIBBLES - 1));
    assign w_idx_nxt = r_idx + IDX_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)              w_state_nxt = RUN;
            RUN:     if (w_capture && w_last)   w_state_nxt = DONE;
            DONE:    if (out_ready)             w_state_nxt = IDLE;
            default:                            w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Adder inputs come straight from registers so each nibble is stable for the
    // full CLA_LAT+1 cycles; the carry register doubles as the adder carry-in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_cla_a <= '0;
            r_cla_b <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_cla_a <= a[NIBBLE_W-1:0];
            r_cla_b <= b[NIBBLE_W-1:0];
        end else if (r_state == RUN) begin
            if (w_capture) begin
                r_sum[NIBBLE_W*r_idx +: NIBBLE_W] <= cla_s;
                r_carry <= cla_cout;
                r_cnt   <= '0;
                if (w_last) begin
                    // Top nibble's MSB is the sum sign bit.
                    r_ovf <= (r_a[W-1] == r_b[W-1]) & (cla_s[NIBBLE_W-1] != r_a[W-1]);
                end else begin
                    r_idx   <= w_idx_nxt;
                    r_cla_a <= r_a[NIBBLE_W*w_idx_nxt +: NIBBLE_W];
                    r_cla_b <= r_b[NIBBLE_W*w_idx_nxt +: NIBBLE_W];
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign sum       = r_sum;
    assign cout      = r_carry;
    assign ovf       = r_ovf;
    assign cla_a     = r_cla_a;
    assign cla_b     = r_cla_b;
    assign cla_c0    = r_carry;

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Bench for cla_nibble_sequencer with a behavioural two-stage registered 4-bit adder
// standing in for cla_4_bit; 16-bit and 8-bit instances.
module tb_cla_nibble_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, out_valid, out_ready, cin, cout, ovf;
    logic [15:0] a, b, sum;
    logic [3:0]  cla_a, cla_b, cla_s;
    logic        cla_c0, cla_cout;

    logic        in_valid2, in_ready2, out_valid2, out_ready2, cin2, cout2, ovf2;
    logic [7:0]  a2, b2, sum2;
    logic [3:0]  cla_a2, cla_b2, cla_s2;
    logic        cla_c02, cla_cout2;

    cla_nibble_sequencer #(.NIBBLES(4), .CLA_LAT(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .cla_a(cla_a), .cla_b(cla_b),
        .cla_c0(cla_c0), .cla_s(cla_s), .cla_cout(cla_cout)
    );

    cla_nibble_sequencer #(.NIBBLES(2), .CLA_LAT(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .cin(cin2), .out_valid(out_valid2), .out_ready(out_ready2),
        .sum(sum2), .cout(cout2), .ovf(ovf2), .cla_a(cla_a2), .cla_b(cla_b2),
        .cla_c0(cla_c02), .cla_s(cla_s2), .cla_cout(cla_cout2)
    );

    // Registered adder models: input register, then output register.
    logic [3:0] m_a, m_b, m_a2, m_b2;
    logic       m_c, m_c2;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_a <= '0; m_b <= '0; m_c <= 1'b0; {cla_cout, cla_s} <= '0;
            m_a2 <= '0; m_b2 <= '0; m_c2 <= 1'b0; {cla_cout2, cla_s2} <= '0;
        end else begin
            m_a <= cla_a; m_b <= cla_b; m_c <= cla_c0;
            {cla_cout, cla_s} <= 5'(m_a) + 5'(m_b) + 5'(m_c);
            m_a2 <= cla_a2; m_b2 <= cla_b2; m_c2 <= cla_c02;
            {cla_cout2, cla_s2} <= 5'(m_a2) + 5'(m_b2) + 5'(m_c2);
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] a, b;
        logic        ci;
        logic [15:0] s;
        logic        co, ov;
        logic [3:0]  c0;
    } vec_t;
    vec_t vecs[7];

    // One operation on the 16-bit instance; out_ready is held low for 'hold'
    // cycles in DONE while in_valid is pulsed with junk operands.
    task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                          input logic [15:0] es, input logic eco, input logic eov,
                          input int hold, output int lat, output logic [3:0] c0h);
        int n;
        n   = 0;
        c0h = '0;
        @(negedge clk);
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check("in_ready wait", 32'(in_ready), 1);
        a = ia; b = ib; cin = ic; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat      = 0;
        c0h[0]   = cla_c0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (lat % 3 == 0 && lat < 12) c0h[lat/3] = cla_c0;
        end
        check("out_valid seen", 32'(out_valid), 1);
        check("sum", 32'(sum), 32'(es));
        check("cout", 32'(cout), 32'(eco));
        check("ovf", 32'(ovf), 32'(eov));
        for (int i = 0; i < hold; i++) begin
            in_valid = i[0]; a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1;
            @(posedge clk); #1;
            check("hold sum", 32'(sum), 32'(es));
            check("hold cout", 32'(cout), 32'(eco));
            check("hold ovf", 32'(ovf), 32'(eov));
            check("hold in_ready", 32'(in_ready), 0);
            check("hold out_valid", 32'(out_valid), 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("in_ready after handshake", 32'(in_ready), 1);
        check("out_valid after handshake", 32'(out_valid), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          lat, n, seen;
        logic [3:0]  c0h;
        logic [15:0] ra, rb;
        logic        rc;
        logic [16:0] e;
        logic [7:0]  ra2, rb2;
        logic [8:0]  e2;

        reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst in_ready", 32'(in_ready), 1);
        check("rst out_valid", 32'(out_valid), 0);
        check("rst sum", 32'(sum), 0);
        check("rst cout", 32'(cout), 0);
        check("rst ovf", 32'(ovf), 0);
        check("rst cla_a", 32'(cla_a), 0);
        check("rst cla_b", 32'(cla_b), 0);
        check("rst cla_c0", 32'(cla_c0), 0);
        @(negedge clk);
        reset = 1'b0;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 4'b0000};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 4'b1110};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 4'b1110};
        vecs[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 4'b0001};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 4'b0000};
        vecs[5] = '{16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0, 4'b1110};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 4'b1111};

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].s, vecs[i].co, vecs[i].ov,
                   0, lat, c0h);
            check("latency", 32'(lat), 12);
            check("cla_c0 per nibble", 32'(c0h), 32'(vecs[i].c0));
        end

        run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 5, lat, c0h);

        // Reset five cycles into an operation.
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst sum", 32'(sum), 0);
        check("midrst cout", 32'(cout), 0);
        check("midrst ovf", 32'(ovf), 0);
        check("midrst out_valid", 32'(out_valid), 0);
        check("midrst cla_a", 32'(cla_a), 0);
        check("midrst cla_b", 32'(cla_b), 0);
        check("midrst cla_c0", 32'(cla_c0), 0);
        check("midrst in_ready", 32'(in_ready), 1);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        check("no output after reset", 32'(seen), 0);
        run_op(16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0, 0, lat, c0h);
        check("post-reset latency", 32'(lat), 12);

        for (int k = 0; k < 500; k++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            e  = {1'b0, ra} + {1'b0, rb} + 17'(rc);
            run_op(ra, rb, rc, e[15:0], e[16], (ra[15] == rb[15]) && (e[15] != ra[15]),
                   0, lat, c0h);
        end

        for (int k = 0; k < 500; k++) begin
            ra2 = 8'($urandom); rb2 = 8'($urandom); rc = 1'($urandom);
            e2  = {1'b0, ra2} + {1'b0, rb2} + 9'(rc);
            @(negedge clk);
            n = 0;
            while (!in_ready2 && n < 50) begin @(negedge clk); n++; end
            a2 = ra2; b2 = rb2; cin2 = rc; in_valid2 = 1'b1;
            @(posedge clk); #1;
            in_valid2 = 1'b0;
            n = 0;
            while (!out_valid2 && n < 100) begin @(posedge clk); #1; n++; end
            check("n2 latency", 32'(n), 6);
            check("n2 sum", 32'(sum2), 32'(e2[7:0]));
            check("n2 cout", 32'(cout2), 32'(e2[8]));
            check("n2 ovf", 32'(ovf2), 32'((ra2[7] == rb2[7]) && (e2[7] != ra2[7])));
            out_ready2 = 1'b1;
            @(posedge clk); #1;
            out_ready2 = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
